// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan decoder: anode digit codes,
// lit-segment patterns (g..a, 1 = lit) for 0-9, special codes, FSM states.
// Also a helper that maps a one-cold anode code to a digit index.
package seg_scan_decoder_pkg;

  localparam logic [3:0] ANODE_D0 = 4'b0111;
  localparam logic [3:0] ANODE_D1 = 4'b1110;
  localparam logic [3:0] ANODE_D2 = 4'b1101;
  localparam logic [3:0] ANODE_D3 = 4'b1011;

  localparam logic [6:0] LIT_0 = 7'b0111111;
  localparam logic [6:0] LIT_1 = 7'b0000110;
  localparam logic [6:0] LIT_2 = 7'b1011011;
  localparam logic [6:0] LIT_3 = 7'b1001111;
  localparam logic [6:0] LIT_4 = 7'b1100110;
  localparam logic [6:0] LIT_5 = 7'b1101101;
  localparam logic [6:0] LIT_6 = 7'b1111101;
  localparam logic [6:0] LIT_7 = 7'b0000111;
  localparam logic [6:0] LIT_8 = 7'b1111111;
  localparam logic [6:0] LIT_9 = 7'b1101111;
  localparam logic [6:0] LIT_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

  // Returns {valid, index}; anything other than the four digit codes is invalid.
  function automatic logic [2:0] anode_decode(input logic [3:0] anode_v);
    logic [2:0] r;
    r = 3'b000;
    case (anode_v)
      ANODE_D0: r = {1'b1, 2'd0};
      ANODE_D1: r = {1'b1, 2'd1};
      ANODE_D2: r = {1'b1, 2'd2};
      ANODE_D3: r = {1'b1, 2'd3};
      default:  r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_pattern_decode.sv
// Combinational segment decoder: active-low seg[6:0] -> {code, blank, err}.
// Zero latency; no flow control.
// All-off decodes to F with blank set; unknown patterns give E with err set.
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  logic [6:0] lit;

  // Map the lit pattern onto a BCD code or one of the two special codes.
  always_comb begin
    lit   = ~seg;
    code  = CODE_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (lit)
      LIT_0:     code = 4'd0;
      LIT_1:     code = 4'd1;
      LIT_2:     code = 4'd2;
      LIT_3:     code = 4'd3;
      LIT_4:     code = 4'd4;
      LIT_5:     code = 4'd5;
      LIT_6:     code = 4'd6;
      LIT_7:     code = 4'd7;
      LIT_8:     code = 4'd8;
      LIT_9:     code = 4'd9;
      LIT_BLANK: begin
        code  = CODE_BLANK;
        blank = 1'b1;
      end
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit value from a multiplexed, active-low 7-segment scan.
// Latency: 2 sync + 1 change-detect + STABLE_CYCLES to accept; frame_valid 1 cycle after 4th digit.
// No backpressure: inputs are sampled free-running, results are pulsed out.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  blank_mask,
  output logic        digit_err,
  output logic        stale,
  output logic [7:0]  frame_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  // Input synchronizer and stability filter state.
  logic [10:0]      sync1_q, sync1_d;
  logic [10:0]      sync2_q, sync2_d;
  logic [10:0]      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Frame assembly state.
  state_e           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      slots_q, slots_d;
  logic [3:0]       pblank_q, pblank_d;
  logic             perr_q, perr_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  // Registered outputs.
  logic [15:0] value_q, value_d;
  logic        frame_valid_q, frame_valid_d;
  logic [3:0]  blank_mask_q, blank_mask_d;
  logic        digit_err_q, digit_err_d;
  logic        stale_q, stale_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic       accept;
  logic       dig_vld;
  logic [1:0] dig_idx;
  logic [3:0] dig_bit;
  logic [3:0] dec_code;
  logic       dec_blank;
  logic       dec_err;

  seg_pattern_decode u_decode (
    .seg   (sync2_q[6:0]),
    .code  (dec_code),
    .blank (dec_blank),
    .err   (dec_err)
  );

  // Synchronize inputs and accept a digit once per stable run, when the
  // counter first reaches its saturation value.
  always_comb begin
    sync1_d = {anode, seg};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    {dig_vld, dig_idx} = anode_decode(sync2_q[10:7]);
    dig_bit = 4'b0001 << dig_idx;
    accept  = (sync2_q == prev_q) && (cnt_q == CNT_LAST) && dig_vld;
  end

  // Frame FSM: gather four digits, abandon on idle timeout, publish for one cycle.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    slots_d       = slots_q;
    pblank_d      = pblank_q;
    perr_d        = perr_q;
    timer_d       = timer_q;
    value_d       = value_q;
    frame_valid_d = 1'b0;
    blank_mask_d  = blank_mask_q;
    digit_err_d   = digit_err_q;
    stale_d       = stale_q;
    frame_count_d = frame_count_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (accept) begin
          slots_d[{dig_idx, 2'b00} +: 4] = dec_code;
          pblank_d[dig_idx] = dec_blank;
          perr_d  = perr_q | dec_err;
          mask_d  = mask_q | dig_bit;
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (accept) begin
          // A repeated digit overwrites its slot; the blank bit follows the slot.
          slots_d[{dig_idx, 2'b00} +: 4] = dec_code;
          pblank_d[dig_idx] = dec_blank;
          perr_d  = perr_q | dec_err;
          mask_d  = mask_q | dig_bit;
          timer_d = '0;
          if ((mask_q | dig_bit) == 4'hF) begin
            state_d = ST_PUBLISH;
          end
        end else if (timer_q == TMR_LAST) begin
          mask_d   = '0;
          pblank_d = '0;
          perr_d   = 1'b0;
          timer_d  = '0;
          stale_d  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_PUBLISH: begin
        value_d       = slots_q;
        blank_mask_d  = pblank_q;
        digit_err_d   = perr_q;
        frame_valid_d = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        stale_d       = 1'b0;
        mask_d        = '0;
        pblank_d      = '0;
        perr_d        = 1'b0;
        timer_d       = '0;
        state_d       = ST_IDLE;
        // A digit landing on the publish cycle opens the next frame.
        if (accept) begin
          slots_d[{dig_idx, 2'b00} +: 4] = dec_code;
          pblank_d[dig_idx] = dec_blank;
          perr_d  = dec_err;
          mask_d  = dig_bit;
          state_d = ST_COLLECT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      slots_q       <= '0;
      pblank_q      <= '0;
      perr_q        <= 1'b0;
      timer_q       <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      blank_mask_q  <= '0;
      digit_err_q   <= 1'b0;
      stale_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      mask_q        <= mask_d;
      slots_q       <= slots_d;
      pblank_q      <= pblank_d;
      perr_q        <= perr_d;
      timer_q       <= timer_d;
      value_q       <= value_d;
      frame_valid_q <= frame_valid_d;
      blank_mask_q  <= blank_mask_d;
      digit_err_q   <= digit_err_d;
      stale_q       <= stale_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = frame_valid_q;
  assign blank_mask  = blank_mask_q;
  assign digit_err   = digit_err_q;
  assign stale       = stale_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus a randomized scan stream,
// checked against a frame-level reference model (digit table, masks, counters).
// Short timeout parameter keeps the abandoned-frame case fast.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 200;

  logic        clk_osc = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  blank_mask;
  logic        digit_err;
  logic        stale;
  logic [7:0]  frame_count;

  always #5 clk_osc = ~clk_osc;

  seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_osc     (clk_osc),
    .reset       (reset),
    .anode       (anode),
    .seg         (seg),
    .value       (value),
    .frame_valid (frame_valid),
    .blank_mask  (blank_mask),
    .digit_err   (digit_err),
    .stale       (stale),
    .frame_count (frame_count)
  );

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;

  // Count every frame_valid pulse seen by the bench.
  always @(negedge clk_osc) if (frame_valid === 1'b1) fv_seen++;

  // Reference tables straight from the digit-select and segment definitions.
  logic [3:0] AN [4]  = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
  logic [6:0] LIT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111};

  // Reference model state.
  logic [3:0]  m_code [4];
  logic [3:0]  m_mask, m_blank;
  logic        m_err;
  logic [15:0] exp_value;
  logic [3:0]  exp_blank;
  logic        exp_err, exp_stale;
  logic [7:0]  exp_count;
  int          exp_fv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_osc);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    anode = a;
    seg   = s;
    step(n);
  endtask

  task automatic model_clear_pending();
    m_mask  = 4'h0;
    m_blank = 4'h0;
    m_err   = 1'b0;
    for (int i = 0; i < 4; i++) m_code[i] = 4'h0;
  endtask

  task automatic model_reset();
    model_clear_pending();
    exp_value = 16'h0;
    exp_blank = 4'h0;
    exp_err   = 1'b0;
    exp_stale = 1'b0;
    exp_count = 8'h0;
  endtask

  task automatic ref_decode(input logic [6:0] lit, output logic [3:0] code,
                            output logic blank, output logic err);
    code  = 4'hE;
    blank = 1'b0;
    err   = 1'b1;
    if (lit == 7'h00) begin
      code  = 4'hF;
      blank = 1'b1;
      err   = 1'b0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (LIT[i] == lit) begin
          code = 4'(i);
          err  = 1'b0;
        end
      end
    end
  endtask

  task automatic model_accept(input int d, input logic [6:0] lit);
    logic [3:0] c;
    logic b, e;
    ref_decode(lit, c, b, e);
    m_code[d]  = c;
    m_blank[d] = b;
    m_err      = m_err | e;
    m_mask[d]  = 1'b1;
    if (m_mask == 4'hF) begin
      exp_value = {m_code[3], m_code[2], m_code[1], m_code[0]};
      exp_blank = m_blank;
      exp_err   = m_err;
      exp_stale = 1'b0;
      exp_count = exp_count + 8'd1;
      exp_fv++;
      model_clear_pending();
    end
  endtask

  // Show one digit for 'hold' cycles, then a blank-anode gap between digits.
  task automatic scan(input int d, input logic [6:0] lit, input int hold);
    drive(AN[d], ~lit, hold);
    drive(4'hF, 7'h7F, 4);
    if (hold >= STABLE + 1) model_accept(d, lit);
  endtask

  task automatic check_all(input string tag);
    @(negedge clk_osc);
    check({tag, ".value"}, 32'(value), 32'(exp_value));
    check({tag, ".blank"}, 32'(blank_mask), 32'(exp_blank));
    check({tag, ".err"},   32'(digit_err), 32'(exp_err));
    check({tag, ".stale"}, 32'(stale), 32'(exp_stale));
    check({tag, ".count"}, 32'(frame_count), 32'(exp_count));
    check({tag, ".fv"},    32'(fv_seen), 32'(exp_fv));
  endtask

  task automatic apply_reset();
    anode = 4'hF;
    seg   = 7'h7F;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int d, r, hold;
    logic [6:0] lit;

    // Reset state.
    apply_reset();
    check_all("reset");
    check("reset.fv_level", 32'(frame_valid), 32'd0);

    // Basic frame 5,9,5,9.
    scan(0, LIT[5], 8);
    scan(1, LIT[9], 8);
    scan(2, LIT[5], 8);
    scan(3, LIT[9], 8);
    check_all("scan5959");
    check("scan5959.literal", 32'(value), 32'h9595);

    // Short, glitched run on digit0 must not be accepted.
    drive(AN[0], ~LIT[5], 1);
    drive(AN[0], ~LIT[3], 1);
    drive(AN[0], ~LIT[5], 1);
    drive(4'hF, 7'h7F, 4);
    scan(1, LIT[2], 8);
    scan(2, LIT[4], 8);
    scan(3, LIT[6], 8);
    check_all("glitch_incomplete");
    scan(0, LIT[7], 8);
    check_all("glitch_complete");

    // Blank digit 2; an invalid multi-hot anode mid-frame is ignored.
    scan(0, LIT[1], 8);
    scan(1, LIT[1], 8);
    drive(4'b1100, ~LIT[8], 8);
    scan(2, 7'h00, 8);
    scan(3, LIT[1], 8);
    check_all("blank2");
    check("blank2.literal", 32'(value), 32'h1F11);

    // Undecodable pattern on digit1.
    scan(0, LIT[2], 8);
    scan(1, 7'b1000000, 8);
    scan(2, LIT[3], 8);
    scan(3, LIT[4], 8);
    check_all("err1");

    // Partial frame abandoned on idle timeout, then a good frame clears stale.
    scan(0, LIT[8], 8);
    scan(1, LIT[8], 8);
    drive(4'hF, 7'h7F, TMO + 10);
    model_clear_pending();
    exp_stale = 1'b1;
    check_all("timeout");
    scan(0, LIT[0], 8);
    scan(1, LIT[1], 8);
    scan(2, LIT[2], 8);
    scan(3, LIT[3], 8);
    check_all("after_timeout");

    // Reset after three digits discards the frame.
    scan(0, LIT[6], 8);
    scan(1, LIT[6], 8);
    scan(2, LIT[6], 8);
    apply_reset();
    check_all("midreset");
    scan(0, LIT[4], 8);
    scan(1, LIT[3], 8);
    scan(2, LIT[2], 8);
    scan(3, LIT[1], 8);
    check_all("post_reset_frame");

    // Randomized scan stream: digit order, patterns and hold lengths vary.
    for (int k = 0; k < 60; k++) begin
      d = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 7)       lit = LIT[$urandom_range(0, 9)];
      else if (r == 7) lit = 7'h00;
      else             lit = 7'($urandom);
      r = $urandom_range(0, 6);
      hold = (r < 2) ? (2 + r) : (4 + r);
      scan(d, lit, hold);
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
